neuron_sigmoid_pipe: RTL and testbench

Parametrised sigmoid neuron with selectable MAC parallelism, start/done handshake and a registered forward/backward sequencer. It computes a fixed-point weighted sum plus bias, applies a piecewise-linear sigmoid, and on request performs one gradient-descent update of all weights and the bias. It sits inside a layer wrapper that broadcasts inputs and collects `y`, `dz_out` and `w_out` per neuron.

---
 rtl/neuron_sigmoid_pipe.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_neuron_sigmoid_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_sigmoid_pipe.sv
// neuron_sigmoid_pipe
// Fixed-point sigmoid neuron: LANES-wide multiply-accumulate of x*w plus bias,
// piecewise-linear sigmoid, and a one-shot gradient-descent update of all
// weights and the bias. A start/done handshake drives a registered sequencer.
//
// Build option: define NEURON_SAT_EN to make every reduction to BITS
// (z, dz, lr*dz, update product, w', b') saturate instead of wrapping.
module neuron_sigmoid_pipe #(
  parameter int N     = 30,
  parameter int BITS  = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [N*BITS-1:0]     x,
  input  logic [N*BITS-1:0]     w,
  input  logic [BITS-1:0]       b,
  input  logic [BITS-1:0]       y_true,
  input  logic [BITS-1:0]       lr,
  output logic                  busy,
  output logic                  done,
  output logic [BITS-1:0]       y,
  output logic                  yhat,
  output logic [BITS-1:0]       dz_out,
  output logic [(N+1)*BITS-1:0] w_out
);

  // Steps per pass, operand storage padded to whole lane groups.
  localparam int K     = (N + LANES - 1) / LANES;
  localparam int NP    = K * LANES;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int W2    = 2 * BITS;
  localparam int ACC_W = 2 * BITS + $clog2(N) + 1;

  localparam logic [KW-1:0] K_ONE  = KW'(32'd1);
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);

  // Sigmoid breakpoints on |z| (width BITS+1 so |-2^(BITS-1)| fits).
  localparam logic [BITS:0]   T_5    = (BITS+1)'(32'd5 << FRAC);
  localparam logic [BITS:0]   T_2375 = (BITS+1)'(32'd19 << (FRAC - 3));
  localparam logic [BITS:0]   T_1    = (BITS+1)'(32'd1 << FRAC);
  localparam logic [BITS:0]   A_ONE  = (BITS+1)'(32'd1);
  localparam logic [BITS-1:0] ONE_Q  = BITS'(32'd1 << FRAC);
  localparam logic [BITS-1:0] C_HI   = BITS'(32'd27 << (FRAC - 5));  // 0.84375
  localparam logic [BITS-1:0] C_MID  = BITS'(32'd5 << (FRAC - 3));   // 0.625
  localparam logic [BITS-1:0] C_LO   = BITS'(32'd1 << (FRAC - 1));   // 0.5

`ifdef NEURON_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-BITS+1){1'b0}}, {(BITS-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD_MAC,
    ST_FWD_ACT,
    ST_BWD_ERR,
    ST_BWD_UPD,
    ST_BWD_BIAS,
    ST_DONE
  } state_t;

  // Reduce a wide signed value to BITS: saturate or two's-complement wrap.
  function automatic logic signed [BITS-1:0] red_f(input logic signed [ACC_W-1:0] v);
`ifdef NEURON_SAT_EN
    if (v > SAT_MAX) begin
      red_f = SAT_MAX[BITS-1:0];
    end else if (v < SAT_MIN) begin
      red_f = SAT_MIN[BITS-1:0];
    end else begin
      red_f = v[BITS-1:0];
    end
`else
    red_f = v[BITS-1:0];
`endif
  endfunction

  // Sign-extend a word to accumulator width.
  function automatic logic signed [ACC_W-1:0] ext_w(input logic signed [BITS-1:0] v);
    ext_w = $signed({{(ACC_W-BITS){v[BITS-1]}}, v});
  endfunction

  // Sign-extend a full product to accumulator width.
  function automatic logic signed [ACC_W-1:0] ext_p(input logic signed [W2-1:0] v);
    ext_p = $signed({{(ACC_W-W2){v[W2-1]}}, v});
  endfunction

  // Full-precision signed product of two words.
  function automatic logic signed [W2-1:0] mul_f(input logic signed [BITS-1:0] a,
                                                 input logic signed [BITS-1:0] c);
    logic signed [W2-1:0] ae;
    logic signed [W2-1:0] ce;
    ae    = $signed({{BITS{a[BITS-1]}}, a});
    ce    = $signed({{BITS{c[BITS-1]}}, c});
    mul_f = ae * ce;
  endfunction

  // Rescale a product back to Q format (arithmetic shift) and reduce.
  function automatic logic signed [BITS-1:0] rescale_f(input logic signed [W2-1:0] p);
    rescale_f = red_f(ext_p(p) >>> FRAC);
  endfunction

  // Piecewise-linear sigmoid; shifts truncate, negative side mirrors 1-f(|z|).
  function automatic logic signed [BITS-1:0] sig_f(input logic signed [BITS-1:0] z);
    logic [BITS:0]   a;
    logic [BITS-1:0] f;
    if (z[BITS-1]) begin
      a = ~{1'b1, z} + A_ONE;
    end else begin
      a = {1'b0, z};
    end
    if (a >= T_5) begin
      f = ONE_Q;
    end else if (a >= T_2375) begin
      f = BITS'(a >> 5) + C_HI;
    end else if (a >= T_1) begin
      f = BITS'(a >> 3) + C_MID;
    end else begin
      f = BITS'(a >> 2) + C_LO;
    end
    if (z[BITS-1]) begin
      sig_f = ONE_Q - f;
    end else begin
      sig_f = f;
    end
  endfunction

  state_t                   state_r;
  logic                     mode_r;
  logic                     busy_r;
  logic                     done_r;
  logic [KW-1:0]            k_r;
  logic signed [BITS-1:0]   x_r [NP];
  logic signed [BITS-1:0]   w_r [NP];
  logic signed [BITS-1:0]   b_r;
  logic signed [BITS-1:0]   y_true_r;
  logic signed [BITS-1:0]   lr_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [BITS-1:0]   z_r;
  logic signed [BITS-1:0]   y_r;
  logic                     yhat_r;
  logic signed [BITS-1:0]   dz_r;
  logic signed [BITS-1:0]   step_r;
  logic signed [BITS-1:0]   wo_r [N];
  logic signed [BITS-1:0]   bo_r;

  logic signed [BITS-1:0]   xs_s  [LANES];
  logic signed [BITS-1:0]   ws_s  [LANES];
  logic signed [BITS-1:0]   upd_s [LANES];
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [BITS-1:0]   z_s;
  logic signed [BITS-1:0]   dz_s;
  logic signed [BITS-1:0]   step_s;

  // Per-lane operand select for the current step k.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      xs_s[j] = '0;
      ws_s[j] = '0;
      for (int k = 0; k < K; k++) begin
        xs_s[j] = (k_r == KW'(k)) ? x_r[k*LANES + j] : xs_s[j];
        ws_s[j] = (k_r == KW'(k)) ? w_r[k*LANES + j] : ws_s[j];
      end
    end
  end

  // Lane products: MAC sum for forward, scaled weight deltas for backward.
  always_comb begin
    sum_s = '0;
    for (int j = 0; j < LANES; j++) begin
      sum_s    = sum_s + ext_p(mul_f(xs_s[j], ws_s[j]));
      upd_s[j] = rescale_f(mul_f(step_r, xs_s[j]));
    end
  end

  // Pre-activation, error and learning step derived from registered state.
  always_comb begin
    z_s    = red_f(acc_r >>> FRAC);
    dz_s   = red_f(ext_w(y_r) - ext_w(y_true_r));
    step_s = rescale_f(mul_f(lr_r, dz_s));
  end

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      mode_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      k_r      <= '0;
      b_r      <= '0;
      y_true_r <= '0;
      lr_r     <= '0;
      acc_r    <= '0;
      z_r      <= '0;
      y_r      <= '0;
      yhat_r   <= 1'b0;
      dz_r     <= '0;
      step_r   <= '0;
      bo_r     <= '0;
      for (int i = 0; i < NP; i++) begin
        x_r[i] <= '0;
        w_r[i] <= '0;
      end
      for (int i = 0; i < N; i++) begin
        wo_r[i] <= '0;
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              x_r[i] <= x[i*BITS +: BITS];
              w_r[i] <= w[i*BITS +: BITS];
            end
            for (int i = N; i < NP; i++) begin
              x_r[i] <= '0;
              w_r[i] <= '0;
            end
            b_r      <= b;
            y_true_r <= y_true;
            lr_r     <= lr;
            mode_r   <= mode;
            busy_r   <= 1'b1;
            k_r      <= '0;
            acc_r    <= ext_w(b) <<< FRAC;
            state_r  <= mode ? ST_BWD_ERR : ST_FWD_MAC;
          end
        end
        ST_FWD_MAC: begin
          acc_r <= acc_r + sum_s;
          if (k_r == K_LAST) begin
            k_r     <= '0;
            state_r <= ST_FWD_ACT;
          end else begin
            k_r <= k_r + K_ONE;
          end
        end
        ST_FWD_ACT: begin
          z_r     <= z_s;
          state_r <= ST_DONE;
        end
        ST_BWD_ERR: begin
          dz_r    <= dz_s;
          step_r  <= step_s;
          k_r     <= '0;
          state_r <= ST_BWD_UPD;
        end
        ST_BWD_UPD: begin
          for (int i = 0; i < N; i++) begin
            if (k_r == KW'(i / LANES)) begin
              wo_r[i] <= red_f(ext_w(w_r[i]) - ext_w(upd_s[i % LANES]));
            end
          end
          if (k_r == K_LAST) begin
            k_r     <= '0;
            state_r <= ST_BWD_BIAS;
          end else begin
            k_r <= k_r + K_ONE;
          end
        end
        ST_BWD_BIAS: begin
          bo_r    <= red_f(ext_w(b_r) - ext_w(step_r));
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          if (!mode_r) begin
            y_r    <= sig_f(z_r);
            yhat_r <= ~z_r[BITS-1];
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign y      = y_r;
  assign yhat   = yhat_r;
  assign dz_out = dz_r;

  // Pack updated parameters: slice 0 is the bias, slice i+1 is weight i.
  always_comb begin
    w_out          = '0;
    w_out[BITS-1:0] = bo_r;
    for (int i = 0; i < N; i++) begin
      w_out[(i+1)*BITS +: BITS] = wo_r[i];
    end
  end

endmodule

// File: tb/tb_neuron_sigmoid_pipe.sv
// Directed, table-driven bench for neuron_sigmoid_pipe (N=4/LANES=2 plus an
// N=5 instance for the odd-length case). Expected values are hand-computed.
module tb_neuron_sigmoid_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // N=4 instance
  logic        start4, mode4;
  logic [63:0] x4, w4;
  logic [15:0] b4, yt4, lr4;
  logic        busy4, done4, yhat4;
  logic [15:0] y4, dz4;
  logic [79:0] wo4;

  // N=5 instance
  logic        start5, mode5;
  logic [79:0] x5, w5;
  logic [15:0] b5, yt5, lr5;
  logic        busy5, done5, yhat5;
  logic [15:0] y5, dz5;
  logic [95:0] wo5;

  neuron_sigmoid_pipe #(.N(4), .BITS(16), .FRAC(8), .LANES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4),
    .x(x4), .w(w4), .b(b4), .y_true(yt4), .lr(lr4),
    .busy(busy4), .done(done4), .y(y4), .yhat(yhat4),
    .dz_out(dz4), .w_out(wo4)
  );

  neuron_sigmoid_pipe #(.N(5), .BITS(16), .FRAC(8), .LANES(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .mode(mode5),
    .x(x5), .w(w5), .b(b5), .y_true(yt5), .lr(lr5),
    .busy(busy5), .done(done5), .y(y5), .yhat(yhat5),
    .dz_out(dz5), .w_out(wo5)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] xv, wv, bv, ytv, lrv;
    logic        md;
    int          edge_e;
    logic [15:0] y_e;
    logic        yhat_e;
    logic [15:0] dz_e, w_e, b_e;
  } vec_t;

  vec_t vecs[10];

  // One operation on the N=4 instance; inputs are scrambled after acceptance.
  task automatic run4(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv,
                      input logic [15:0] ytv, input logic [15:0] lrv, input logic md,
                      output int dedge, output logic busy_e0, output logic [15:0] dz_e1);
    x4 = {4{xv}}; w4 = {4{wv}}; b4 = bv; yt4 = ytv; lr4 = lrv;
    mode4 = md; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; mode4 = ~md;
    x4 = ~x4; w4 = ~w4; b4 = ~b4; yt4 = ~yt4; lr4 = ~lr4;
    busy_e0 = busy4;
    dedge = -1;
    dz_e1 = 16'h0000;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 1) dz_e1 = dz4;
      if (done4) begin
        dedge = e;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dedge;
    logic        be0;
    logic [15:0] dze1;
    int          ndone;
    logic [15:0] y_ovf;
    logic        yh_ovf;

`ifdef NEURON_SAT_EN
    y_ovf = 16'h0100; yh_ovf = 1'b1;
`else
    y_ovf = 16'h0008; yh_ovf = 1'b0;
`endif
    //            x         w         b         y_true    lr        md   edge y_e       yhat  dz_e      w_e       b_e
    vecs[0] = '{16'h0100, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4, 16'h00C0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{16'h0100, 16'h0040, 16'h0000, 16'h0100, 16'h0080, 1'b1, 5, 16'h00C0, 1'b1, 16'hFFC0, 16'h0060, 16'h0020};
    vecs[2] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4, 16'h0080, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{16'h0100, 16'h0000, 16'hFB00, 16'h0000, 16'h0000, 1'b0, 4, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4, y_ovf,    yh_ovf, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{16'h0100, 16'hFFA0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4, 16'h0030, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[6] = '{16'h0100, 16'h00C0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4, 16'h00F0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[7] = '{16'h0100, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 1'b0, 4, 16'h00A0, 1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[8] = '{16'h0100, 16'h0020, 16'h0010, 16'h0000, 16'h0100, 1'b1, 5, 16'h00A0, 1'b1, 16'h00A0, 16'hFF80, 16'hFF70};
    vecs[9] = '{16'h0100, 16'h0040, 16'h0000, 16'h0103, 16'h0080, 1'b1, 5, 16'h00A0, 1'b1, 16'hFF9D, 16'h0072, 16'h0032};

    rst_n = 1'b0;
    start4 = 1'b0; mode4 = 1'b0; x4 = '0; w4 = '0; b4 = '0; yt4 = '0; lr4 = '0;
    start5 = 1'b0; mode5 = 1'b0; x5 = '0; w5 = '0; b5 = '0; yt5 = '0; lr5 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy4}, 32'd0);
    check("reset_done", {31'd0, done4}, 32'd0);
    check("reset_y", {16'd0, y4}, 32'd0);
    check("reset_yhat", {31'd0, yhat4}, 32'd0);
    check("reset_dz", {16'd0, dz4}, 32'd0);
    check("reset_wout_or", {31'd0, |wo4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back-to-back on the N=4 instance.
    for (int v = 0; v < 10; v++) begin
      run4(vecs[v].xv, vecs[v].wv, vecs[v].bv, vecs[v].ytv, vecs[v].lrv, vecs[v].md, dedge, be0, dze1);
      check($sformatf("v%0d_done_edge", v), dedge, vecs[v].edge_e);
      check($sformatf("v%0d_busy_e0", v), {31'd0, be0}, 32'd1);
      check($sformatf("v%0d_busy_after", v), {31'd0, busy4}, 32'd0);
      check($sformatf("v%0d_y", v), {16'd0, y4}, {16'd0, vecs[v].y_e});
      check($sformatf("v%0d_yhat", v), {31'd0, yhat4}, {31'd0, vecs[v].yhat_e});
      if (vecs[v].md) begin
        check($sformatf("v%0d_dz_e1", v), {16'd0, dze1}, {16'd0, vecs[v].dz_e});
        check($sformatf("v%0d_dz", v), {16'd0, dz4}, {16'd0, vecs[v].dz_e});
        check($sformatf("v%0d_bias", v), {16'd0, wo4[15:0]}, {16'd0, vecs[v].b_e});
        for (int i = 1; i <= 4; i++) begin
          check($sformatf("v%0d_w%0d", v, i), {16'd0, wo4[i*16 +: 16]}, {16'd0, vecs[v].w_e});
        end
      end
    end

    // Odd N: N=5, LANES=2 -> K=3, z = 5.0, done at edge 5.
    @(negedge clk);
    x5 = {5{16'h0100}}; w5 = {5{16'h0100}}; b5 = 16'h0000; mode5 = 1'b0; start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0; x5 = '0; w5 = '0;
    dedge = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (done5) begin
        dedge = e;
        break;
      end
    end
    check("n5_done_edge", dedge, 32'd5);
    check("n5_y", {16'd0, y5}, 32'h0100);
    check("n5_yhat", {31'd0, yhat5}, 32'd1);

    // Reset asserted at edge 1 of a forward: no done, outputs cleared.
    @(negedge clk);
    x4 = {4{16'h0100}}; w4 = {4{16'h0040}}; b4 = '0; mode4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("rst_mid_y", {16'd0, y4}, 32'd0);
    check("rst_mid_dz", {16'd0, dz4}, 32'd0);
    check("rst_mid_wout_or", {31'd0, |wo4}, 32'd0);
    check("rst_mid_busy", {31'd0, busy4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done4) ndone++;
    end
    check("rst_mid_no_done", ndone, 32'd0);
    check("rst_mid_yhat", {31'd0, yhat4}, 32'd0);

    // start held high through busy and DONE, mode flipped: one forward only.
    @(negedge clk);
    x4 = {4{16'h0100}}; w4 = {4{16'h0040}}; b4 = '0; yt4 = 16'h0100; lr4 = 16'h0080;
    mode4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    mode4 = 1'b1;
    ndone = 0;
    dedge = -1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (done4) begin
        ndone++;
        if (dedge < 0) dedge = e;
        start4 = 1'b0;
      end
    end
    start4 = 1'b0;
    check("hold_done_count", ndone, 32'd1);
    check("hold_done_edge", dedge, 32'd4);
    check("hold_y", {16'd0, y4}, 32'h00C0);
    check("hold_dz_untouched", {16'd0, dz4}, 32'd0);
    check("hold_busy_end", {31'd0, busy4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
